fpnew_result_fifo: RTL and testbench

- Output decoupling buffer placed directly downstream of an operation-group block.
- Captures result, status, extension bit and tag through a valid/ready handshake and stores them in order in a small circular FIFO.
- Presents the stored entries to the top-level output arbiter.
- Also keeps a sticky accumulator of exception flags for all retired results, read by the CSR logic.

---
 rtl/fpnew_pkg.sv | 17 +
 rtl/fpnew_result_fifo.sv | 123 ++++++++++++
 tb/tb_fpnew_result_fifo.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPU types: exception flag layout and buffer sizing helpers.
package fpnew_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  // Pointer width for a circular buffer; never below one bit.
  function automatic int unsigned fifo_ptr_bits(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

endpackage

// File: rtl/fpnew_result_fifo.sv
// Output decoupling FIFO behind an operation group, with sticky exception
// flag accumulation over every retired result.
module fpnew_result_fifo
  import fpnew_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 4,
  parameter type         TagType = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [Width-1:0]           in_result_i,
  input  status_t                    in_status_i,
  input  logic                       in_ext_bit_i,
  input  TagType                     in_tag_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [Width-1:0]           out_result_o,
  output status_t                    out_status_o,
  output logic                       out_ext_bit_o,
  output TagType                     out_tag_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output status_t                    fflags_o,
  input  logic                       fflags_clr_i,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic                       busy_o
);

  localparam int unsigned PtrW = fifo_ptr_bits(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext_bit;
    TagType           tag;
  } entry_t;

  entry_t          storage_q [Depth];
  entry_t          head;
  entry_t          in_entry;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  status_t         fflags_q, fflags_d;
  logic            push, pop, write_en;

  // Wrap at Depth-1 so non power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign in_ready_o = (count_q != FullCnt);
  assign out_valid_o = (count_q != '0);
  assign busy_o = (count_q != '0);
  assign usage_o = count_q;
  assign fflags_o = fflags_q;

  assign head = storage_q[rd_ptr_q];
  assign out_result_o = head.result;
  assign out_status_o = head.status;
  assign out_ext_bit_o = head.ext_bit;
  assign out_tag_o = head.tag;

  assign in_entry = '{result: in_result_i, status: in_status_i,
                      ext_bit: in_ext_bit_i, tag: in_tag_i};

  // Next-state for pointers, occupancy and sticky flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fflags_d = fflags_q;
    push     = in_valid_i & in_ready_o;
    pop      = out_valid_o & out_ready_i;
    write_en = push & ~flush_i;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end

    // Clear takes effect before the popped status is merged in.
    if (fflags_clr_i) fflags_d = '0;
    if (pop && !flush_i) fflags_d = status_t'(fflags_d | head.status);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) storage_q[i] <= '0;
    end else if (write_en) begin
      storage_q[wr_ptr_q] <= in_entry;
    end
  end

endmodule

// File: tb/tb_fpnew_result_fifo.sv
// Scoreboard bench for fpnew_result_fifo: directed pushes feed an expected
// queue, a negedge monitor checks every popped head entry in order.
module tb_fpnew_result_fifo;
  import fpnew_pkg::*;

  typedef logic [3:0] tag_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  status;
    logic        ext_bit;
    tag_t        tag;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] in_result_i = '0;
  logic [4:0]  in_status_i = '0;
  logic        in_ext_bit_i = 1'b0;
  tag_t        in_tag_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        flush_i = 1'b0;
  logic [31:0] out_result_o;
  status_t     out_status_o;
  logic        out_ext_bit_o;
  tag_t        out_tag_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  status_t     fflags_o;
  logic        fflags_clr_i = 1'b0;
  logic [2:0]  usage_o;
  logic        busy_o;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t exp_q[$];

  fpnew_result_fifo #(.Width(32), .Depth(4), .TagType(tag_t)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_result_i(in_result_i), .in_status_i(in_status_i),
    .in_ext_bit_i(in_ext_bit_i), .in_tag_i(in_tag_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .flush_i(flush_i),
    .out_result_o(out_result_o), .out_status_o(out_status_o),
    .out_ext_bit_o(out_ext_bit_o), .out_tag_o(out_tag_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .usage_o(usage_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one push; the expected entry is queued when the handshake is due.
  task automatic drive(input logic [31:0] r, input logic [4:0] s, input logic e, input tag_t t);
    in_valid_i   = 1'b1;
    in_result_i  = r;
    in_status_i  = s;
    in_ext_bit_i = e;
    in_tag_i     = t;
  endtask

  task automatic expect_push(input logic [31:0] r, input logic [4:0] s, input logic e, input tag_t t);
    exp_q.push_back('{result: r, status: s, ext_bit: e, tag: t});
  endtask

  // Monitor: compares each popped head entry against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      exp_t got;
      got = '{result: out_result_o, status: out_status_o,
              ext_bit: out_ext_bit_o, tag: out_tag_o};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no entry", got);
      end else begin
        exp_t want;
        want = exp_q.pop_front();
        if (got !== want) begin
          tests_failed++;
          $display("FAIL pop_entry: got res=0x%0h st=%b ext=%b tag=%0d, expected res=0x%0h st=%b ext=%b tag=%0d",
                   got.result, got.status, got.ext_bit, got.tag,
                   want.result, want.status, want.ext_bit, want.tag);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #12;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_usage", 32'(usage_o), 32'd0);
    check("rst_fflags", 32'(fflags_o), 32'd0);
    rst_i = 1'b0;
    step();

    // 1: single push, visible next cycle, flags accumulate after pop
    out_ready_i = 1'b1;
    drive(32'h3F80_0000, 5'b00001, 1'b1, 4'd1);
    expect_push(32'h3F80_0000, 5'b00001, 1'b1, 4'd1);
    check("t1_no_fallthrough", 32'(out_valid_o), 32'd0);
    step();
    in_valid_i = 1'b0;
    check("t1_out_valid", 32'(out_valid_o), 32'd1);
    step();
    check("t1_fflags", 32'(fflags_o), 32'h01);
    check("t1_usage", 32'(usage_o), 32'd0);

    // 2: fill with back-pressure, fifth push refused
    out_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(32'h1000 + 32'(i), 5'b00000, 1'(i % 2), 4'(i));
      check("t2_in_ready", 32'(in_ready_o), (i <= 4) ? 32'd1 : 32'd0);
      if (i <= 4) begin
        expect_push(32'h1000 + 32'(i), 5'b00000, 1'(i % 2), 4'(i));
        step();
      end
    end
    check("t2_usage_full", 32'(usage_o), 32'd4);

    // 3: full FIFO with simultaneous pop refuses the push
    out_ready_i = 1'b1;
    step();
    check("t3_in_ready", 32'(in_ready_o), 32'd1);
    check("t3_usage", 32'(usage_o), 32'd3);
    expect_push(32'h1005, 5'b00000, 1'b1, 4'd5);
    step();
    in_valid_i = 1'b0;
    check("t3_usage_pushpop", 32'(usage_o), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("t2_stream_valid", 32'(out_valid_o), 32'd1);
      step();
    end
    check("t2_drained", 32'(usage_o), 32'd0);
    check("t2_fflags", 32'(fflags_o), 32'h01);

    // 4: flush drops held entries and a concurrent push; flags untouched
    out_ready_i = 1'b0;
    drive(32'hA000_0001, 5'b10000, 1'b0, 4'd6); step();
    drive(32'hA000_0002, 5'b00100, 1'b0, 4'd7); step();
    drive(32'hA000_0003, 5'b00001, 1'b0, 4'd8); step();
    check("t4_usage_held", 32'(usage_o), 32'd3);
    drive(32'hA000_0004, 5'b00010, 1'b0, 4'd9);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    check("t4_out_valid", 32'(out_valid_o), 32'd0);
    check("t4_usage", 32'(usage_o), 32'd0);
    check("t4_fflags", 32'(fflags_o), 32'h01);
    step();
    check("t4_busy", 32'(busy_o), 32'd0);

    // 5: clear together with a pop keeps only the popped status
    drive(32'hB000_0001, 5'b00010, 1'b0, 4'd10);
    expect_push(32'hB000_0001, 5'b00010, 1'b0, 4'd10);
    step();
    drive(32'hB000_0002, 5'b01000, 1'b1, 4'd11);
    expect_push(32'hB000_0002, 5'b01000, 1'b1, 4'd11);
    step();
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    step();
    check("t5_fflags_first", 32'(fflags_o), 32'h03);
    fflags_clr_i = 1'b1;
    step();
    check("t5_fflags_clrpop", 32'(fflags_o), 32'h08);
    out_ready_i = 1'b0;
    step();
    fflags_clr_i = 1'b0;
    check("t5_fflags_clr", 32'(fflags_o), 32'h00);

    // 6: asynchronous reset with entries held
    drive(32'hC000_0001, 5'b00100, 1'b0, 4'd12); step();
    drive(32'hC000_0002, 5'b00100, 1'b0, 4'd13); step();
    in_valid_i = 1'b0;
    check("t6_usage_held", 32'(usage_o), 32'd2);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_out_valid", 32'(out_valid_o), 32'd0);
    check("t6_rst_usage", 32'(usage_o), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready_o), 32'd1);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_fflags", 32'(fflags_o), 32'd0);
    exp_q.delete();
    step();
    rst_i = 1'b0;
    step();
    out_ready_i = 1'b1;
    drive(32'hDEAD_BEEF, 5'b00001, 1'b0, 4'd14);
    expect_push(32'hDEAD_BEEF, 5'b00001, 1'b0, 4'd14);
    step();
    in_valid_i = 1'b0;
    check("t6_head_result", out_result_o, 32'hDEAD_BEEF);
    step();
    check("t6_usage_end", 32'(usage_o), 32'd0);
    check("t6_fflags_end", 32'(fflags_o), 32'h01);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
